wb_burst_slave_mem: RTL and testbench
=====================================

Name: wb_burst_slave_mem

Overview:
Parametrised Wishbone B4 registered-feedback slave with word-addressed internal memory, and successor to the single-slave block. It adds depth/width parameters, burst support (constant and incrementing CTI with BTE linear/wrap-4/8/16), byte-lane writes, out-of-range error termination and a beat counter. It sits on the slave side of a Wishbone master in the single-clock domain.

Parameters:
ADDR_WIDTH, 5, word address width on adr_i
DATA_WIDTH, 32, data bus width; must be a multiple of 8
SEL_WIDTH, DATA_WIDTH/8, byte-select width
DEPTH, 24, implemented words; must be ≤ 2**ADDR_WIDTH; addresses ≥ DEPTH are unmapped
CNT_WIDTH, 8, width of beat counter
WAIT_CYCLES, 2, extra wait states per classic cycle; only used with WB_WAIT_STATES_EN

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
adr_i  in  ADDR_WIDTH  word address
dat_i  in  DATA_WIDTH  write data
dat_o  out  DATA_WIDTH  read data
we_i  in  1  1 = write
sel_i  in  SEL_WIDTH  byte lane enables
stb_i  in  1  strobe
cyc_i  in  1  cycle valid
cti_i  in  3  cycle type: 000 classic, 001 constant, 010 incrementing, 111 end-of-burst
bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
ack_o  out  1  normal termination
err_o  out  1  error termination
beat_cnt_o  out  CNT_WIDTH  beats terminated in current cycle, saturating
state_o  out  2  00 IDLE, 01 CLASSIC, 10 BURST, 11 ERROR

Behaviour:
- Reset: rst_i sampled at the clock edge. dat_o=0, ack_o=0, err_o=0, beat_cnt_o=0, state_o=IDLE, internal address=0. Memory contents are not reset. Reset mid-burst aborts immediately with no write on that edge.
- Request means cyc_i&stb_i. ack_o and err_o are mutually exclusive and never asserted while the request is low.
- IDLE: on a request, latch adr_i into the internal address (iadr).
  - If adr_i ≥ DEPTH: go to ERROR.
  - Else if cti_i is 001 or 010: go to BURST.
  - Else (000, 111, reserved 011–110): go to CLASSIC.
- CLASSIC: ack_o=1 for exactly one cycle, one cycle after the request is sampled. Read: dat_o=mem[iadr] in the same cycle as ack. Write: bytes with sel_i=1 are written on the ack edge. Then return to IDLE; ack_o is low for at least one cycle before the next ack.
- BURST:
  - First ack is one cycle after the request. Afterwards ack_o=1 every cycle the request is high (zero wait states).
  - On each acked beat, iadr advances:
    - cti 001: iadr unchanged.
    - cti 010, bte 00: iadr+1.
    - cti 010, wrap-N: low log2(N) bits increment modulo N, upper bits held.
  - Read data for the next beat is read from the advanced iadr so that dat_o is valid together with ack.
  - stb_i low with cyc_i high: wait state. ack_o=0, iadr held, and the burst resumes when stb_i returns.
  - A beat with cti_i=111 is acked normally, then the state returns to IDLE.
  - If the advanced iadr ≥ DEPTH on a linear burst, that beat gets err_o instead of ack_o, no write occurs, and the state goes to ERROR.
- ERROR: err_o=1 for one cycle per request beat, dat_o=0, no memory write. Exit to IDLE when cyc_i falls.
- cyc_i low in any state: next state IDLE, ack_o/err_o=0 next cycle, beat_cnt_o cleared. No write occurs on the cycle cyc_i is low.
- beat_cnt_o: +1 per ack_o or err_o, saturates at 2**CNT_WIDTH-1, cleared when a new cycle starts from IDLE.
- sel_i=0 on a write: ack is returned, memory is unchanged.

Optional Feature:
WB_WAIT_STATES_EN.
- Defined: CLASSIC inserts WAIT_CYCLES extra cycles before ack_o, so the classic ack arrives 1+WAIT_CYCLES cycles after the request. A down-counter is reloaded on entry. A request drop during the wait aborts the cycle to IDLE with no write. Bursts are unaffected.
- Undefined: classic ack latency is exactly 1 cycle and WAIT_CYCLES is ignored.

Test Plan:
- Classic write adr=3, dat=0xDEADBEEF, sel=1111, then classic read adr=3 -> each ack one cycle after request; read dat_o=0xDEADBEEF; beat_cnt_o=1.
- Byte-lane write adr=3, dat=0x00000011, sel=0001 over 0xDEADBEEF -> read 0xDEADBE11.
- Incrementing linear write burst at adr=4, 4 beats (cti 010,010,010,111), data 0x10..0x13, then burst read -> acks on 4 consecutive cycles; words 4..7 = 0x10..0x13; beat_cnt_o=4; state back to IDLE.
- Wrap4 read burst starting adr=6, 4 beats -> words accessed in order 6,7,4,5; stb_i dropped 2 cycles after beat 2 -> no ack in those cycles, beat 3 returns word 4.
- DEPTH=24: classic read adr=25 -> err_o one cycle, dat_o=0, ack_o=0. Linear burst from adr=22, 4 beats -> ack, ack, err on beat 3; memory 22/23 written only.
- Assert rst_i during beat 2 of a write burst -> outputs 0 next cycle, state IDLE, beat-2 word unchanged. With WB_WAIT_STATES_EN and WAIT_CYCLES=2: classic ack 3 cycles after request.

Source files
------------

// File: rtl/wb_burst_slave_mem.sv
// ---------------------------------------------------------------------------
// wb_burst_slave_mem
//   Wishbone B4 registered-feedback slave backed by a word-addressed memory.
//   Classic cycles, constant/incrementing bursts (linear, wrap-4/8/16),
//   byte-lane writes, error termination for unmapped words, beat counter.
//
// Build option:
//   WB_WAIT_STATES_EN  when defined, classic cycles insert WAIT_CYCLES extra
//                      cycles before ack_o; bursts are unaffected.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), synchronous active-high reset
//   adr_i               word address
//   dat_i / dat_o       write / read data
//   we_i, sel_i         write enable, byte-lane enables
//   stb_i, cyc_i        strobe, cycle valid
//   cti_i, bte_i        cycle type / burst type
//   ack_o, err_o        normal / error termination
//   beat_cnt_o          beats terminated in the current cycle (saturating)
//   state_o             00 IDLE, 01 CLASSIC, 10 BURST, 11 ERROR
// ---------------------------------------------------------------------------

// One byte lane of the backing memory. Read is asynchronous so the top can
// register the next beat's data in the same edge it advances the address;
// a same-edge write to the read address is forwarded.
module wb_burst_slave_mem_lane #(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 24
) (
  input  logic                  clk_i,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_adr,
  input  logic [7:0]            wr_byte,
  input  logic [ADDR_WIDTH-1:0] rd_adr,
  output logic [7:0]            rd_byte
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_adr[IW-1:0]] <= wr_byte;
  end

  assign rd_byte = (wr_en && (wr_adr == rd_adr)) ? wr_byte : mem[rd_adr[IW-1:0]];
endmodule

module wb_burst_slave_mem #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = DATA_WIDTH / 8,
  parameter int DEPTH       = 24,
  parameter int CNT_WIDTH   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic                  we_i,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  input  logic                  stb_i,
  input  logic                  cyc_i,
  input  logic [2:0]            cti_i,
  input  logic [1:0]            bte_i,
  output logic                  ack_o,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  beat_cnt_o,
  output logic [1:0]            state_o
);
  localparam int AWX = ADDR_WIDTH + 1;
  localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [AWX-1:0] DEPTH_C = AWX'(DEPTH);

`ifdef WB_WAIT_STATES_EN
  localparam int unsigned WAITS = WAIT_CYCLES;
`else
  localparam int unsigned WAITS = 0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CLASSIC = 2'b01,
    ST_BURST   = 2'b10,
    ST_ERROR   = 2'b11
  } state_t;

  // ack/err hold "termination ready for the current beat"; the outputs are
  // qualified by the live request so a stb_i gap stalls without losing it.
  typedef struct packed {
    state_t                st;
    logic [ADDR_WIDTH-1:0] iadr;
    logic                  ack;
    logic                  err;
    logic [DATA_WIDTH-1:0] dat;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [WCW-1:0]        wcnt;
  } regs_t;

  regs_t r_q, r_d;

  logic                                wr_go;
  logic [ADDR_WIDTH-1:0]               rd_adr;
  logic [SEL_WIDTH-1:0][7:0]           rd_lanes;
  logic [DATA_WIDTH-1:0]               rd_word;
  logic [AWX-1:0]                      nadr;
  logic                                burst_cti;
  logic [CNT_WIDTH-1:0]                cnt_inc;

  // Address after an acked beat, one bit wider so a linear burst running
  // off the top of the map is visible. Wrap modes only carry within the
  // low bits selected by the mask.
  function automatic logic [AWX-1:0] next_adr(input logic [ADDR_WIDTH-1:0] a,
                                              input logic [2:0] cti,
                                              input logic [1:0] bte);
    logic [AWX-1:0] e, inc, m;
    e   = {1'b0, a};
    inc = e + AWX'(1);
    unique case (bte)
      2'b01:   m = AWX'(3);
      2'b10:   m = AWX'(7);
      2'b11:   m = AWX'(15);
      default: m = '1;
    endcase
    if (cti == 3'b001) return e;
    return (e & ~m) | (inc & m);
  endfunction

  assign burst_cti = (cti_i == 3'b001) || (cti_i == 3'b010);
  assign nadr      = next_adr(r_q.iadr, cti_i, bte_i);
  assign cnt_inc   = (r_q.cnt == '1) ? r_q.cnt : r_q.cnt + CNT_WIDTH'(1);

  genvar l;
  generate
    for (l = 0; l < SEL_WIDTH; l++) begin : g_lane
      wb_burst_slave_mem_lane #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
      ) u_lane (
        .clk_i   (clk_i),
        .wr_en   (wr_go & sel_i[l] & ~rst_i),
        .wr_adr  (r_q.iadr),
        .wr_byte (dat_i[8*l +: 8]),
        .rd_adr  (rd_adr),
        .rd_byte (rd_lanes[l])
      );
    end
  endgenerate

  assign rd_word = rd_lanes;

  always_comb begin
    r_d    = r_q;
    wr_go  = 1'b0;
    rd_adr = r_q.iadr;
    unique case (r_q.st)
      ST_IDLE: begin
        rd_adr = adr_i;
        r_d.ack = 1'b0;
        r_d.err = 1'b0;
        if (!cyc_i) begin
          r_d.cnt = '0;
        end else if (stb_i) begin
          r_d.iadr = adr_i;
          r_d.cnt  = '0;
          if ({1'b0, adr_i} >= DEPTH_C) begin
            r_d.st  = ST_ERROR;
            r_d.err = 1'b1;
            r_d.dat = '0;
          end else if (burst_cti) begin
            r_d.st  = ST_BURST;
            r_d.ack = 1'b1;
            r_d.dat = rd_word;
          end else begin
            r_d.st   = ST_CLASSIC;
            r_d.wcnt = WCW'(WAITS);
            if (WAITS == 0) begin
              r_d.ack = 1'b1;
              r_d.dat = rd_word;
            end
          end
        end
      end

      ST_CLASSIC: begin
        if (!cyc_i) begin
          r_d.st  = ST_IDLE;
          r_d.ack = 1'b0;
          r_d.cnt = '0;
        end else if (r_q.ack) begin
          if (stb_i) begin
            wr_go   = we_i;
            r_d.cnt = cnt_inc;
            r_d.st  = ST_IDLE;
            r_d.ack = 1'b0;
          end
        end else if (!stb_i) begin
          // request dropped while still counting wait states
          r_d.st = ST_IDLE;
        end else if (r_q.wcnt <= WCW'(1)) begin
          r_d.ack = 1'b1;
          r_d.dat = rd_word;
        end else begin
          r_d.wcnt = r_q.wcnt - WCW'(1);
        end
      end

      ST_BURST: begin
        rd_adr = nadr[ADDR_WIDTH-1:0];
        if (!cyc_i) begin
          r_d.st  = ST_IDLE;
          r_d.ack = 1'b0;
          r_d.cnt = '0;
        end else if (stb_i) begin
          wr_go   = we_i;
          r_d.cnt = cnt_inc;
          if (!burst_cti) begin
            // 111 (and any non-burst type) ends the burst after this beat
            r_d.st  = ST_IDLE;
            r_d.ack = 1'b0;
          end else if (nadr >= DEPTH_C) begin
            r_d.st  = ST_ERROR;
            r_d.ack = 1'b0;
            r_d.err = 1'b1;
            r_d.dat = '0;
          end else begin
            r_d.iadr = nadr[ADDR_WIDTH-1:0];
            r_d.dat  = rd_word;
          end
        end
      end

      ST_ERROR: begin
        if (!cyc_i) begin
          r_d.st  = ST_IDLE;
          r_d.err = 1'b0;
          r_d.cnt = '0;
        end else if (stb_i) begin
          r_d.cnt = cnt_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_q <= '0;
    else       r_q <= r_d;
  end

  assign ack_o      = r_q.ack & cyc_i & stb_i;
  assign err_o      = r_q.err & cyc_i & stb_i;
  assign dat_o      = r_q.dat;
  assign beat_cnt_o = r_q.cnt;
  assign state_o    = r_q.st;
endmodule

// File: tb/tb_wb_burst_slave_mem.sv
// Directed bench for wb_burst_slave_mem (default parameters, DEPTH=24).
module tb_wb_burst_slave_mem;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [4:0]  adr_i = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        we_i  = 1'b0;
  logic [3:0]  sel_i = '0;
  logic        stb_i = 1'b0;
  logic        cyc_i = 1'b0;
  logic [2:0]  cti_i = '0;
  logic [1:0]  bte_i = '0;
  logic        ack_o;
  logic        err_o;
  logic [7:0]  beat_cnt_o;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  wb_burst_slave_mem dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .adr_i      (adr_i),
    .dat_i      (dat_i),
    .dat_o      (dat_o),
    .we_i       (we_i),
    .sel_i      (sel_i),
    .stb_i      (stb_i),
    .cyc_i      (cyc_i),
    .cti_i      (cti_i),
    .bte_i      (bte_i),
    .ack_o      (ack_o),
    .err_o      (err_o),
    .beat_cnt_o (beat_cnt_o),
    .state_o    (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [2:0] ct, input logic [1:0] bt);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a;
    dat_i = d; sel_i = s; cti_i = ct; bte_i = bt;
  endtask

  task automatic idle();
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cti_i = 3'b000; bte_i = 2'b00;
    tick();
  endtask

  task automatic classic_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    req(1'b1, a, d, s, 3'b000, 2'b00);
    tick();
    tick();
    idle();
  endtask

  task automatic classic_read(input string tag, input logic [4:0] a, input logic [31:0] exp);
    req(1'b0, a, 32'h0, 4'hF, 3'b000, 2'b00);
    tick();
    chk({tag, "_ack"}, ack_o, 1'b1);
    chk({tag, "_dat"}, dat_o, exp);
    tick();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    tick(); tick();
    rst_i = 1'b0;
    chk("rst_ack", ack_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_cnt", beat_cnt_o, 8'd0);
    chk("rst_state", state_o, 2'b00);

    // classic write adr 3
    req(1'b1, 5'd3, 32'hDEADBEEF, 4'hF, 3'b000, 2'b00);
    #1 chk("cw_ack_pre", ack_o, 1'b0);
    tick();
    chk("cw_ack", ack_o, 1'b1);
    chk("cw_state", state_o, 2'b01);
    tick();
    chk("cw_ack_low", ack_o, 1'b0);
    chk("cw_cnt", beat_cnt_o, 8'd1);
    chk("cw_idle", state_o, 2'b00);
    idle();
    chk("cw_cnt_clr", beat_cnt_o, 8'd0);

    // classic read adr 3
    req(1'b0, 5'd3, 32'h0, 4'hF, 3'b000, 2'b00);
    tick();
    chk("cr_ack", ack_o, 1'b1);
    chk("cr_dat", dat_o, 32'hDEADBEEF);
    tick();
    chk("cr_cnt", beat_cnt_o, 8'd1);
    chk("cr_ack_low", ack_o, 1'b0);
    idle();

    // byte-lane write, then sel=0 write leaves memory untouched
    classic_write(5'd3, 32'h00000011, 4'b0001);
    classic_read("bl", 5'd3, 32'hDEADBE11);
    req(1'b1, 5'd3, 32'hFFFFFFFF, 4'b0000, 3'b000, 2'b00);
    tick();
    chk("sel0_ack", ack_o, 1'b1);
    tick();
    idle();
    classic_read("sel0", 5'd3, 32'hDEADBE11);

    // linear write burst at 4, four beats
    req(1'b1, 5'd4, 32'h10, 4'hF, 3'b010, 2'b00);
    tick();
    chk("lw_state", state_o, 2'b10);
    for (int i = 0; i < 4; i++) begin
      dat_i = 32'h10 + i;
      cti_i = (i == 3) ? 3'b111 : 3'b010;
      #1 chk($sformatf("lw_ack%0d", i), ack_o, 1'b1);
      tick();
    end
    chk("lw_ack_end", ack_o, 1'b0);
    chk("lw_cnt", beat_cnt_o, 8'd4);
    chk("lw_idle", state_o, 2'b00);
    idle();

    // linear read burst at 4
    req(1'b0, 5'd4, 32'h0, 4'hF, 3'b010, 2'b00);
    tick();
    for (int i = 0; i < 4; i++) begin
      cti_i = (i == 3) ? 3'b111 : 3'b010;
      #1 chk($sformatf("lr_ack%0d", i), ack_o, 1'b1);
      chk($sformatf("lr_dat%0d", i), dat_o, 32'h10 + i);
      tick();
    end
    chk("lr_cnt", beat_cnt_o, 8'd4);
    chk("lr_idle", state_o, 2'b00);
    idle();

    // wrap4 read burst from 6: words 6,7,4,5 with a 2-cycle stb gap after beat 2
    req(1'b0, 5'd6, 32'h0, 4'hF, 3'b010, 2'b01);
    tick();
    chk("wr_ack1", ack_o, 1'b1);
    chk("wr_dat1", dat_o, 32'h12);
    tick();
    chk("wr_ack2", ack_o, 1'b1);
    chk("wr_dat2", dat_o, 32'h13);
    tick();
    stb_i = 1'b0;
    #1 chk("wr_gap_a", ack_o, 1'b0);
    tick();
    chk("wr_gap_b", ack_o, 1'b0);
    chk("wr_gap_state", state_o, 2'b10);
    tick();
    stb_i = 1'b1;
    #1 chk("wr_ack3", ack_o, 1'b1);
    chk("wr_dat3", dat_o, 32'h10);
    tick();
    cti_i = 3'b111;
    #1 chk("wr_ack4", ack_o, 1'b1);
    chk("wr_dat4", dat_o, 32'h11);
    tick();
    chk("wr_idle", state_o, 2'b00);
    chk("wr_cnt", beat_cnt_o, 8'd4);
    idle();

    // constant-address read burst at 5
    req(1'b0, 5'd5, 32'h0, 4'hF, 3'b001, 2'b00);
    tick();
    chk("cb_dat1", dat_o, 32'h11);
    tick();
    cti_i = 3'b111;
    #1 chk("cb_ack2", ack_o, 1'b1);
    chk("cb_dat2", dat_o, 32'h11);
    tick();
    chk("cb_cnt", beat_cnt_o, 8'd2);
    idle();

    // unmapped classic read
    req(1'b0, 5'd25, 32'h0, 4'hF, 3'b000, 2'b00);
    tick();
    chk("oob_err", err_o, 1'b1);
    chk("oob_ack", ack_o, 1'b0);
    chk("oob_dat", dat_o, 32'h0);
    chk("oob_state", state_o, 2'b11);
    cyc_i = 1'b0; stb_i = 1'b0;
    #1 chk("oob_err_drop", err_o, 1'b0);
    tick();
    chk("oob_exit", state_o, 2'b00);

    // linear write burst from 22 runs off the map on beat 3
    req(1'b1, 5'd22, 32'hA0, 4'hF, 3'b010, 2'b00);
    tick();
    chk("ob_ack1", ack_o, 1'b1);
    tick();
    dat_i = 32'hA1;
    #1 chk("ob_ack2", ack_o, 1'b1);
    tick();
    dat_i = 32'hA2;
    #1 chk("ob_err3", err_o, 1'b1);
    chk("ob_ack3", ack_o, 1'b0);
    chk("ob_state", state_o, 2'b11);
    tick();
    chk("ob_cnt", beat_cnt_o, 8'd3);
    idle();
    classic_read("ob22", 5'd22, 32'hA0);
    classic_read("ob23", 5'd23, 32'hA1);

    // reset during beat 2 of a write burst
    classic_write(5'd9, 32'h55, 4'hF);
    req(1'b1, 5'd8, 32'hB0, 4'hF, 3'b010, 2'b00);
    tick();
    tick();
    dat_i = 32'hB1;
    rst_i = 1'b1;
    tick();
    chk("rb_ack", ack_o, 1'b0);
    chk("rb_err", err_o, 1'b0);
    chk("rb_dat", dat_o, 32'h0);
    chk("rb_cnt", beat_cnt_o, 8'd0);
    chk("rb_state", state_o, 2'b00);
    rst_i = 1'b0;
    idle();
    classic_read("rb9", 5'd9, 32'h55);
    classic_read("rb8", 5'd8, 32'hB0);

`ifdef WB_WAIT_STATES_EN
    // classic ack 3 cycles after the request
    req(1'b0, 5'd3, 32'h0, 4'hF, 3'b000, 2'b00);
    tick();
    chk("ws_ack0", ack_o, 1'b0);
    tick();
    chk("ws_ack1", ack_o, 1'b0);
    tick();
    chk("ws_ack2", ack_o, 1'b1);
    chk("ws_dat", dat_o, 32'hDEADBE11);
    tick();
    idle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
